// File: rtl/divide.sv
// -----------------------------------------------------------------------------
// divide -- sequential signed integer divider (restoring, one quotient bit/cycle)
//
// A division is started by sampling start=1 while idle; both operands are
// captured on that edge. The magnitudes are then divided over L1 cycles and a
// final cycle applies the signs and publishes the result with a one-cycle done
// pulse. Latency from the start edge to done is always L1+1 cycles.
//
// Parameters
//   L1 : dividend / quotient width (>= 2)
//   L2 : divisor / remainder width (>= 2)
//
// Ports
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   start    : request a division (ignored while busy)
//   in1      : signed dividend
//   in2      : signed divisor
//   busy     : division in progress
//   done     : one-cycle pulse, quot/rem/div_zero valid
//   quot     : signed quotient, truncated toward zero
//   rem      : signed remainder, takes the sign of the dividend
//   div_zero : last division had a zero divisor
// -----------------------------------------------------------------------------
module divide #(
  parameter int L1 = 8,
  parameter int L2 = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [L1-1:0] in1,
  input  logic [L2-1:0] in2,
  output logic          busy,
  output logic          done,
  output logic [L1-1:0] quot,
  output logic [L2-1:0] rem,
  output logic          div_zero
);

  // One extra bit so that the most negative value of either operand has a
  // representable magnitude.
  localparam int W  = ((L1 > L2) ? L1 : L2) + 1;
  localparam int CW = $clog2(L1 + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [L1-1:0] dvd_q, dvd_d;     // dividend magnitude, shifts into quotient
  logic [W-1:0]  dvs_q, dvs_d;     // divisor magnitude
  logic [W-1:0]  prem_q, prem_d;   // partial remainder
  logic          qneg_q, qneg_d;   // quotient must be negated
  logic          rneg_q, rneg_d;   // remainder must be negated
  logic          zero_q, zero_d;   // divisor was zero
  logic [L1-1:0] quot_q, quot_d;
  logic [L2-1:0] rem_q, rem_d;
  logic          dz_q, dz_d;
  logic          done_q, done_d;

  logic [W-1:0]  in1_ext, in2_ext, in1_mag, in2_mag;
  logic [W-1:0]  trial, diff;
  logic          qbit;
  logic          unused_bits;

  // Operand magnitudes in W bits.
  always_comb begin
    in1_ext = {{(W-L1){in1[L1-1]}}, in1};
    in2_ext = {{(W-L2){in2[L2-1]}}, in2};
    in1_mag = in1[L1-1] ? -in1_ext : in1_ext;
    in2_mag = in2[L2-1] ? -in2_ext : in2_ext;
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    trial = {prem_q[W-2:0], dvd_q[L1-1]};
    qbit  = (trial >= dvs_q);
    diff  = trial - dvs_q;
  end

  // The partial remainder never reaches its top bit and the dividend
  // magnitude always fits in L1 bits.
  assign unused_bits = ^{in1_mag[W-1:L1], prem_q[W-1]};

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (cnt_q == CW'(L1 - 1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    case (state_q)
      CALC, FIX: busy = 1'b1;
      default:   busy = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_comb begin
    cnt_d  = cnt_q;
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    prem_d = prem_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    zero_d = zero_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    dz_d   = dz_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d  = '0;
          dvd_d  = in1_mag[L1-1:0];
          dvs_d  = in2_mag;
          prem_d = '0;
          qneg_d = in1[L1-1] ^ in2[L2-1];
          rneg_d = in1[L1-1];
          zero_d = (in2 == '0);
        end
      end
      CALC: begin
        cnt_d  = cnt_q + 1'b1;
        prem_d = qbit ? diff : trial;
        dvd_d  = {dvd_q[L1-2:0], qbit};
      end
      FIX: begin
        done_d = 1'b1;
        if (zero_q) begin
          quot_d = '1;
          rem_d  = '0;
          dz_d   = 1'b1;
        end else begin
          // Most-negative / -1 yields magnitude 2^(L1-1) with a positive
          // sign, which wraps to the most negative value as required.
          quot_d = qneg_q ? -dvd_q : dvd_q;
          rem_d  = rneg_q ? -prem_q[L2-1:0] : prem_q[L2-1:0];
          dz_d   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      prem_q <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      zero_q <= 1'b0;
      quot_q <= '0;
      rem_q  <= '0;
      dz_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      prem_q <= prem_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      zero_q <= zero_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dz_q   <= dz_d;
      done_q <= done_d;
    end
  end

  assign done     = done_q;
  assign quot     = quot_q;
  assign rem      = rem_q;
  assign div_zero = dz_q;

endmodule
